l1_l2_arbiter: RTL and testbench

Sequential arbiter that shares the single L2 request port between the L1 instruction cache and the L1 data cache. It sits between the two L1 tops and the L2 top, replacing the combinational L1-to-L2 mux. It grants one requester at a time with round-robin priority. It sequences an L1D dirty-line write-back followed by its refill as one atomic grant, and routes the L2 ready strobe back only to the granted cache.

---
 rtl/l1_l2_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_l1_l2_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/l1_l2_arbiter.sv
// Round-robin arbiter sharing the single L2 request port between L1I and L1D.
// Write-back plus refill for L1D is served as one atomic grant; all outputs are registered.
module l1_l2_arbiter #(
   parameter int TAG_W  = 18,
   parameter int IDX_W  = 8,
   parameter int LINE_W = 512
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              read_L1I_L2,
   input  logic [TAG_W-1:0]  tag_L1I_L2,
   input  logic [IDX_W-1:0]  index_L1I_L2,
   input  logic              read_L1D_L2,
   input  logic              write_L1D_L2,
   input  logic [TAG_W-1:0]  tag_L1D_L2,
   input  logic [IDX_W-1:0]  index_L1D_L2,
   input  logic [TAG_W-1:0]  write_tag_L1D_L2,
   input  logic [IDX_W-1:0]  write_index_L1D_L2,
   input  logic [LINE_W-1:0] write_data_L1D_L2,
   input  logic              ready_L2_L1,
   output logic              ready_L2_L1I,
   output logic              ready_L2_L1D,
   output logic              read_L1_L2,
   output logic              write_L1_L2,
   output logic [TAG_W-1:0]  tag_L1_L2,
   output logic [IDX_W-1:0]  index_L1_L2,
   output logic [LINE_W-1:0] write_data_L1_L2
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_I_RD    = 3'd1,
      ST_D_WB    = 3'd2,
      ST_D_RD    = 3'd3,
      ST_RELEASE = 3'd4
   } state_t;

   state_t              state_r;
   state_t              state_nx_s;
   logic                rr_r;
   logic                rr_nx_s;
   logic                i_req_s;
   logic                d_req_s;
   logic                read_nx_s;
   logic                write_nx_s;
   logic                rdy_i_nx_s;
   logic                rdy_d_nx_s;
   logic [TAG_W-1:0]    tag_nx_s;
   logic [IDX_W-1:0]    index_nx_s;
   logic [LINE_W-1:0]   data_nx_s;

   assign i_req_s = read_L1I_L2;
   assign d_req_s = read_L1D_L2 | write_L1D_L2;

   // State, round-robin pointer and all output registers
   always_ff @(posedge clk) begin
      if (nrst) begin
         state_r          <= ST_IDLE;
         rr_r             <= 1'b0;
         read_L1_L2       <= 1'b0;
         write_L1_L2      <= 1'b0;
         ready_L2_L1I     <= 1'b0;
         ready_L2_L1D     <= 1'b0;
         tag_L1_L2        <= {TAG_W{1'b0}};
         index_L1_L2      <= {IDX_W{1'b0}};
         write_data_L1_L2 <= {LINE_W{1'b0}};
      end else begin
         state_r          <= state_nx_s;
         rr_r             <= rr_nx_s;
         read_L1_L2       <= read_nx_s;
         write_L1_L2      <= write_nx_s;
         ready_L2_L1I     <= rdy_i_nx_s;
         ready_L2_L1D     <= rdy_d_nx_s;
         tag_L1_L2        <= tag_nx_s;
         index_L1_L2      <= index_nx_s;
         write_data_L1_L2 <= data_nx_s;
      end
   end

   // Next-state and round-robin update; rr always points at the loser of the last grant
   always_comb begin
      state_nx_s = state_r;
      rr_nx_s    = rr_r;
      case (state_r)
         ST_IDLE: begin
            if (i_req_s && (!d_req_s || !rr_r)) begin
               state_nx_s = ST_I_RD;
               rr_nx_s    = 1'b1;
            end else if (d_req_s) begin
               state_nx_s = write_L1D_L2 ? ST_D_WB : ST_D_RD;
               rr_nx_s    = 1'b0;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_I_RD: begin
            if (ready_L2_L1) begin
               state_nx_s = ST_RELEASE;
            end else begin
               state_nx_s = ST_I_RD;
            end
         end
         ST_D_WB: begin
            if (ready_L2_L1) begin
               state_nx_s = read_L1D_L2 ? ST_D_RD : ST_RELEASE;
            end else begin
               state_nx_s = ST_D_WB;
            end
         end
         ST_D_RD: begin
            if (ready_L2_L1) begin
               state_nx_s = ST_RELEASE;
            end else begin
               state_nx_s = ST_D_RD;
            end
         end
         ST_RELEASE: state_nx_s = ST_IDLE;
         default:    state_nx_s = ST_IDLE;
      endcase
   end

   // Next output values: address/data load only on entry to a grant state, then hold
   always_comb begin
      read_nx_s  = 1'b0;
      write_nx_s = 1'b0;
      tag_nx_s   = tag_L1_L2;
      index_nx_s = index_L1_L2;
      data_nx_s  = write_data_L1_L2;
      case (state_nx_s)
         ST_I_RD: begin
            read_nx_s = 1'b1;
            if (state_r != ST_I_RD) begin
               tag_nx_s   = tag_L1I_L2;
               index_nx_s = index_L1I_L2;
            end else begin
               tag_nx_s   = tag_L1_L2;
               index_nx_s = index_L1_L2;
            end
         end
         ST_D_WB: begin
            write_nx_s = 1'b1;
            if (state_r != ST_D_WB) begin
               tag_nx_s   = write_tag_L1D_L2;
               index_nx_s = write_index_L1D_L2;
               data_nx_s  = write_data_L1D_L2;
            end else begin
               tag_nx_s   = tag_L1_L2;
               index_nx_s = index_L1_L2;
               data_nx_s  = write_data_L1_L2;
            end
         end
         ST_D_RD: begin
            read_nx_s = 1'b1;
            if (state_r != ST_D_RD) begin
               tag_nx_s   = tag_L1D_L2;
               index_nx_s = index_L1D_L2;
            end else begin
               tag_nx_s   = tag_L1_L2;
               index_nx_s = index_L1_L2;
            end
         end
         default: begin
            read_nx_s  = 1'b0;
            write_nx_s = 1'b0;
         end
      endcase
   end

   // Completion strobes; a write-back followed by its refill stays silent towards L1D
   always_comb begin
      rdy_i_nx_s = 1'b0;
      rdy_d_nx_s = 1'b0;
      case (state_r)
         ST_I_RD: rdy_i_nx_s = ready_L2_L1;
         ST_D_WB: rdy_d_nx_s = ready_L2_L1 & ~read_L1D_L2;
         ST_D_RD: rdy_d_nx_s = ready_L2_L1;
         default: begin
            rdy_i_nx_s = 1'b0;
            rdy_d_nx_s = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Randomized bench for l1_l2_arbiter: the bench plays both L1 caches and L2,
// predicting each grant from the round-robin rule and checking every L2 transaction.
module tb_l1_l2_arbiter;
   localparam int TAG_W  = 18;
   localparam int IDX_W  = 8;
   localparam int LINE_W = 512;
   localparam int W      = LINE_W;

   logic              clk = 1'b0;
   logic              nrst;
   logic              read_L1I_L2;
   logic [TAG_W-1:0]  tag_L1I_L2;
   logic [IDX_W-1:0]  index_L1I_L2;
   logic              read_L1D_L2;
   logic              write_L1D_L2;
   logic [TAG_W-1:0]  tag_L1D_L2;
   logic [IDX_W-1:0]  index_L1D_L2;
   logic [TAG_W-1:0]  write_tag_L1D_L2;
   logic [IDX_W-1:0]  write_index_L1D_L2;
   logic [LINE_W-1:0] write_data_L1D_L2;
   logic              ready_L2_L1;
   logic              ready_L2_L1I;
   logic              ready_L2_L1D;
   logic              read_L1_L2;
   logic              write_L1_L2;
   logic [TAG_W-1:0]  tag_L1_L2;
   logic [IDX_W-1:0]  index_L1_L2;
   logic [LINE_W-1:0] write_data_L1_L2;

   int total = 0;
   int bad   = 0;
   bit rr_m;
   bit srv;

   l1_l2_arbiter #(.TAG_W(TAG_W), .IDX_W(IDX_W), .LINE_W(LINE_W)) dut (
      .clk(clk), .nrst(nrst),
      .read_L1I_L2(read_L1I_L2), .tag_L1I_L2(tag_L1I_L2), .index_L1I_L2(index_L1I_L2),
      .read_L1D_L2(read_L1D_L2), .write_L1D_L2(write_L1D_L2),
      .tag_L1D_L2(tag_L1D_L2), .index_L1D_L2(index_L1D_L2),
      .write_tag_L1D_L2(write_tag_L1D_L2), .write_index_L1D_L2(write_index_L1D_L2),
      .write_data_L1D_L2(write_data_L1D_L2), .ready_L2_L1(ready_L2_L1),
      .ready_L2_L1I(ready_L2_L1I), .ready_L2_L1D(ready_L2_L1D),
      .read_L1_L2(read_L1_L2), .write_L1_L2(write_L1_L2),
      .tag_L1_L2(tag_L1_L2), .index_L1_L2(index_L1_L2),
      .write_data_L1_L2(write_data_L1_L2)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic new_i();
      read_L1I_L2  = 1'b1;
      tag_L1I_L2   = TAG_W'($urandom);
      index_L1I_L2 = IDX_W'($urandom);
   endtask

   task automatic new_d();
      int kind;
      kind = $urandom_range(0, 2);
      read_L1D_L2        = (kind != 1);
      write_L1D_L2       = (kind != 0);
      tag_L1D_L2         = TAG_W'($urandom);
      index_L1D_L2       = IDX_W'($urandom);
      write_tag_L1D_L2   = TAG_W'($urandom);
      write_index_L1D_L2 = IDX_W'($urandom);
      for (int k = 0; k < LINE_W / 32; k++) write_data_L1D_L2[k*32 +: 32] = $urandom;
   endtask

   // One L2 transaction: hold for dly cycles checking stability, then pulse ready.
   task automatic phase(input string nm, input bit exp_rd, input logic [TAG_W-1:0] et,
                        input logic [IDX_W-1:0] ei, input logic [LINE_W-1:0] ed,
                        input bit chk_data, input int dly, input bit perturb_i);
      for (int k = 0; k <= dly; k++) begin
         check_val({nm, "_rd"}, W'(read_L1_L2), W'(exp_rd));
         check_val({nm, "_wr"}, W'(write_L1_L2), W'(!exp_rd));
         check_val({nm, "_tag"}, W'(tag_L1_L2), W'(et));
         check_val({nm, "_idx"}, W'(index_L1_L2), W'(ei));
         check_val({nm, "_nostb"}, W'({ready_L2_L1I, ready_L2_L1D}), W'(2'b00));
         if (chk_data) check_val({nm, "_data"}, write_data_L1_L2, ed);
         if (perturb_i) tag_L1I_L2 = TAG_W'($urandom);
         if (k == dly) ready_L2_L1 = 1'b1;
         @(negedge clk);
         ready_L2_L1 = 1'b0;
      end
   endtask

   // Serve one grant predicted from the current requests and the model pointer.
   task automatic run_txn(input int dly1, input int dly2, output bit served_i);
      bit win_i, has_rd, has_wr;
      logic [TAG_W-1:0]  it, dwt, drt;
      logic [IDX_W-1:0]  ii, dwi, dri;
      logic [LINE_W-1:0] dd;
      int n;
      has_rd = read_L1D_L2;
      has_wr = write_L1D_L2;
      win_i  = read_L1I_L2 && (!(has_rd || has_wr) || !rr_m);
      it = tag_L1I_L2;  ii = index_L1I_L2;
      dwt = write_tag_L1D_L2; dwi = write_index_L1D_L2; dd = write_data_L1D_L2;
      drt = tag_L1D_L2; dri = index_L1D_L2;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(read_L1_L2 || write_L1_L2) && n < 6);
      check_val("grant_lat", W'(n), W'(1));
      rr_m = win_i;
      served_i = win_i;
      if (win_i) begin
         phase("i_rd", 1'b1, it, ii, {LINE_W{1'b0}}, 1'b0, dly1, 1'b1);
         check_val("stb_i", W'(ready_L2_L1I), W'(1'b1));
         check_val("stb_i_other", W'(ready_L2_L1D), W'(1'b0));
      end else begin
         if (has_wr) phase("d_wb", 1'b0, dwt, dwi, dd, 1'b1, dly1, 1'b0);
         if (has_rd) phase("d_rd", 1'b1, drt, dri, {LINE_W{1'b0}}, 1'b0, has_wr ? dly2 : dly1, 1'b0);
         check_val("stb_d", W'(ready_L2_L1D), W'(1'b1));
         check_val("stb_d_other", W'(ready_L2_L1I), W'(1'b0));
      end
      check_val("stb_req_off", W'({read_L1_L2, write_L1_L2}), W'(2'b00));
   endtask

   task automatic release_step();
      @(negedge clk);
      check_val("rel_stb", W'({ready_L2_L1I, ready_L2_L1D}), W'(2'b00));
      check_val("rel_req", W'({read_L1_L2, write_L1_L2}), W'(2'b00));
   endtask

   task automatic post_rand(input bit served_i);
      if (served_i) begin
         if ($urandom_range(0, 1) == 1) new_i(); else read_L1I_L2 = 1'b0;
         if (!(read_L1D_L2 || write_L1D_L2) && $urandom_range(0, 2) == 0) new_d();
      end else begin
         if ($urandom_range(0, 1) == 1) new_d(); else begin read_L1D_L2 = 1'b0; write_L1D_L2 = 1'b0; end
         if (!read_L1I_L2 && $urandom_range(0, 2) == 0) new_i();
      end
      release_step();
      if (!read_L1I_L2 && !(read_L1D_L2 || write_L1D_L2)) begin
         case ($urandom_range(0, 2))
            0:       new_i();
            1:       new_d();
            default: begin new_i(); new_d(); end
         endcase
      end
   endtask

   initial begin
      nrst = 1'b1;
      ready_L2_L1 = 1'b0;
      read_L1I_L2 = 1'b1; tag_L1I_L2 = 18'h00ABC; index_L1I_L2 = 8'h12;
      read_L1D_L2 = 1'b1; write_L1D_L2 = 1'b1;
      tag_L1D_L2 = 18'h2; index_L1D_L2 = 8'h7;
      write_tag_L1D_L2 = 18'h1; write_index_L1D_L2 = 8'h5;
      write_data_L1D_L2 = {64{8'hA5}};
      repeat (2) begin
         @(negedge clk);
         check_val("rst_req", W'({read_L1_L2, write_L1_L2}), W'(2'b00));
         check_val("rst_stb", W'({ready_L2_L1I, ready_L2_L1D}), W'(2'b00));
         check_val("rst_addr", W'({tag_L1_L2, index_L1_L2}), W'(26'd0));
         check_val("rst_data", write_data_L1_L2, {LINE_W{1'b0}});
      end
      nrst = 1'b0;
      rr_m = 1'b0;

      // directed: L1I first after reset, then the L1D write-back plus refill
      run_txn(5, 0, srv);
      check_val("first_is_i", W'(srv), W'(1'b1));
      read_L1I_L2 = 1'b0;
      release_step();
      run_txn(2, 3, srv);
      read_L1D_L2 = 1'b0; write_L1D_L2 = 1'b0;
      release_step();

      // sustained contention
      new_i(); new_d();
      repeat (4) begin
         run_txn($urandom_range(0, 3), $urandom_range(0, 3), srv);
         if (srv) new_i(); else new_d();
         release_step();
      end
      read_L1I_L2 = 1'b0; read_L1D_L2 = 1'b0; write_L1D_L2 = 1'b0;

      // spurious ready while idle
      ready_L2_L1 = 1'b1;
      @(negedge clk);
      ready_L2_L1 = 1'b0;
      check_val("spur_stb", W'({ready_L2_L1I, ready_L2_L1D}), W'(2'b00));
      check_val("spur_req", W'({read_L1_L2, write_L1_L2}), W'(2'b00));
      @(negedge clk);
      check_val("spur_stb2", W'({ready_L2_L1I, ready_L2_L1D}), W'(2'b00));
      new_i();
      run_txn($urandom_range(0, 4), $urandom_range(0, 4), srv);
      post_rand(srv);

      repeat (60) begin
         run_txn($urandom_range(0, 4), $urandom_range(0, 4), srv);
         post_rand(srv);
      end

      // reset in the middle of a write-back
      read_L1I_L2 = 1'b0;
      new_d();
      read_L1D_L2 = 1'b0; write_L1D_L2 = 1'b1;
      @(negedge clk);
      check_val("mid_pre_wr", W'(write_L1_L2), W'(1'b1));
      nrst = 1'b1;
      ready_L2_L1 = 1'b1;
      @(negedge clk);
      ready_L2_L1 = 1'b0;
      check_val("mid_rst_req", W'({read_L1_L2, write_L1_L2}), W'(2'b00));
      check_val("mid_rst_stb", W'({ready_L2_L1I, ready_L2_L1D}), W'(2'b00));
      check_val("mid_rst_addr", W'({tag_L1_L2, index_L1_L2}), W'(26'd0));
      check_val("mid_rst_data", write_data_L1_L2, {LINE_W{1'b0}});
      @(negedge clk);
      check_val("mid_rst_stb2", W'(ready_L2_L1D), W'(1'b0));
      nrst = 1'b0;
      rr_m = 1'b0;
      new_i();
      run_txn(1, 1, srv);
      check_val("post_rst_i_first", W'(srv), W'(1'b1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
